// File: rtl/core_encode_if.sv
`default_nettype none
// ============================================================================
//  Module   : core_encode_if
//  Purpose  : Request/response bundle of the RV32I instruction encoder.
//             master = request producer / word consumer, slave = encoder.
//  Revision : 1.0  initial release
// ============================================================================
interface core_encode_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_inst
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_inst
  );
endinterface
`default_nettype wire

// File: rtl/core_encode.sv
`default_nettype none
// ============================================================================
//  Module   : core_encode
//  Purpose  : RV32I instruction encoder. Range-checks an op index plus
//             rd/rs1/rs2/imm fields, packs the 32-bit word and queues it in
//             a small output FIFO. IMM uses the decode-stage format, so
//             decode(encode(x)) == x for every legal request.
//  Revision : 1.0  initial release
// ============================================================================
module core_encode #(
  parameter int DEPTH = 2,   // FIFO entries, power of two, >= 2
  parameter int CNT_W = 16   // width of the statistics counters
) (
  input  logic             clk,
  input  logic             rst_n,
  core_encode_if.slave     bus,
  output logic             err_o,
  output logic [CNT_W-1:0] inst_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int               PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]   C_FULL    = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   C_CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] C_STAT_1  = CNT_W'(1);

  // Major opcodes
  localparam logic [6:0] C_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] C_OPC_OP     = 7'b0110011;
  localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] C_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] C_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] C_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] C_F7_ALT     = 7'b0100000;

  typedef enum logic [2:0] {
    FMT_BAD, FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J
  } fmt_e;

  fmt_e        fmt;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] enc_word;
  logic        legal;
  logic        sext12, sext13, sext21;

  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] inst_cnt_q, inst_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic accept, push, pop;

  wire [31:0] imm = bus.in_imm;

  // Immediate range tests: value fits when all bits above the sign bit copy it
  assign sext12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign sext13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign sext21 = (&imm[31:20]) | ~(|imm[31:20]);

  // Op index -> instruction format, major opcode, funct3 and funct7
  always_comb begin
    fmt = FMT_BAD;
    opc = 7'd0;
    f3  = 3'd0;
    f7  = 7'd0;
    case (bus.in_op)
      6'd0:  begin fmt = FMT_I;  opc = C_OPC_OPIMM;  f3 = 3'b000; end
      6'd1:  begin fmt = FMT_I;  opc = C_OPC_OPIMM;  f3 = 3'b010; end
      6'd2:  begin fmt = FMT_I;  opc = C_OPC_OPIMM;  f3 = 3'b011; end
      6'd3:  begin fmt = FMT_I;  opc = C_OPC_OPIMM;  f3 = 3'b100; end
      6'd4:  begin fmt = FMT_I;  opc = C_OPC_OPIMM;  f3 = 3'b110; end
      6'd5:  begin fmt = FMT_I;  opc = C_OPC_OPIMM;  f3 = 3'b111; end
      6'd6:  begin fmt = FMT_SH; opc = C_OPC_OPIMM;  f3 = 3'b001; end
      6'd7:  begin fmt = FMT_SH; opc = C_OPC_OPIMM;  f3 = 3'b101; end
      6'd8:  begin fmt = FMT_SH; opc = C_OPC_OPIMM;  f3 = 3'b101; f7 = C_F7_ALT; end
      6'd9:  begin fmt = FMT_R;  opc = C_OPC_OP;     f3 = 3'b000; end
      6'd10: begin fmt = FMT_R;  opc = C_OPC_OP;     f3 = 3'b000; f7 = C_F7_ALT; end
      6'd11: begin fmt = FMT_R;  opc = C_OPC_OP;     f3 = 3'b001; end
      6'd12: begin fmt = FMT_R;  opc = C_OPC_OP;     f3 = 3'b010; end
      6'd13: begin fmt = FMT_R;  opc = C_OPC_OP;     f3 = 3'b011; end
      6'd14: begin fmt = FMT_R;  opc = C_OPC_OP;     f3 = 3'b100; end
      6'd15: begin fmt = FMT_R;  opc = C_OPC_OP;     f3 = 3'b101; end
      6'd16: begin fmt = FMT_R;  opc = C_OPC_OP;     f3 = 3'b101; f7 = C_F7_ALT; end
      6'd17: begin fmt = FMT_R;  opc = C_OPC_OP;     f3 = 3'b110; end
      6'd18: begin fmt = FMT_R;  opc = C_OPC_OP;     f3 = 3'b111; end
      6'd19: begin fmt = FMT_B;  opc = C_OPC_BRANCH; f3 = 3'b000; end
      6'd20: begin fmt = FMT_B;  opc = C_OPC_BRANCH; f3 = 3'b001; end
      6'd21: begin fmt = FMT_B;  opc = C_OPC_BRANCH; f3 = 3'b100; end
      6'd22: begin fmt = FMT_B;  opc = C_OPC_BRANCH; f3 = 3'b101; end
      6'd23: begin fmt = FMT_B;  opc = C_OPC_BRANCH; f3 = 3'b110; end
      6'd24: begin fmt = FMT_B;  opc = C_OPC_BRANCH; f3 = 3'b111; end
      6'd25: begin fmt = FMT_I;  opc = C_OPC_LOAD;   f3 = 3'b000; end
      6'd26: begin fmt = FMT_I;  opc = C_OPC_LOAD;   f3 = 3'b001; end
      6'd27: begin fmt = FMT_I;  opc = C_OPC_LOAD;   f3 = 3'b010; end
      6'd28: begin fmt = FMT_I;  opc = C_OPC_LOAD;   f3 = 3'b100; end
      6'd29: begin fmt = FMT_I;  opc = C_OPC_LOAD;   f3 = 3'b101; end
      6'd30: begin fmt = FMT_S;  opc = C_OPC_STORE;  f3 = 3'b000; end
      6'd31: begin fmt = FMT_S;  opc = C_OPC_STORE;  f3 = 3'b001; end
      6'd32: begin fmt = FMT_S;  opc = C_OPC_STORE;  f3 = 3'b010; end
      6'd33: begin fmt = FMT_I;  opc = C_OPC_JALR;   f3 = 3'b000; end
      6'd34: begin fmt = FMT_J;  opc = C_OPC_JAL;    end
      6'd35: begin fmt = FMT_U;  opc = C_OPC_AUIPC;  end
      6'd36: begin fmt = FMT_U;  opc = C_OPC_LUI;    end
      default: fmt = FMT_BAD;
    endcase
  end

  // Pack the word for the selected format and apply the immediate range rules
  always_comb begin
    enc_word = 32'd0;
    legal    = 1'b0;
    case (fmt)
      FMT_R: begin
        enc_word = {f7, bus.in_rs2, bus.in_rs1, f3, bus.in_rd, opc};
        legal    = 1'b1;
      end
      FMT_I: begin
        enc_word = {imm[11:0], bus.in_rs1, f3, bus.in_rd, opc};
        legal    = sext12;
      end
      FMT_SH: begin
        enc_word = {f7, imm[4:0], bus.in_rs1, f3, bus.in_rd, opc};
        legal    = ~(|imm[31:5]);
      end
      FMT_S: begin
        enc_word = {imm[11:5], bus.in_rs2, bus.in_rs1, f3, imm[4:0], opc};
        legal    = sext12;
      end
      FMT_B: begin
        enc_word = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, f3,
                    imm[4:1], imm[11], opc};
        legal    = ~imm[0] & sext13;
      end
      FMT_U: begin
        enc_word = {imm[31:12], bus.in_rd, opc};
        legal    = ~(|imm[11:0]);
      end
      FMT_J: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, opc};
        legal    = ~imm[0] & sext21;
      end
      default: begin
        enc_word = 32'd0;
        legal    = 1'b0;
      end
    endcase
  end

  // Handshakes: ready/valid come straight from the occupancy register
  assign bus.in_ready  = (count_q != C_FULL);
  assign bus.out_valid = (count_q != '0);
  assign bus.out_inst  = bus.out_valid ? mem_q[rd_ptr_q] : 32'd0;
  assign accept        = bus.in_valid & bus.in_ready;
  assign push          = accept & legal;
  assign pop           = bus.out_valid & bus.out_ready;

  // Next-state for pointers, occupancy, error pulse and statistics
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + C_PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + C_PTR_ONE : rd_ptr_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + C_CNT_ONE;
      2'b01:   count_d = count_q - C_CNT_ONE;
      default: count_d = count_q;
    endcase
    err_d      = accept & ~legal;
    inst_cnt_d = push ? inst_cnt_q + C_STAT_1 : inst_cnt_q;
    err_cnt_d  = (err_d && (err_cnt_q != '1)) ? err_cnt_q + C_STAT_1 : err_cnt_q;
  end

  // Control state; async reset drops every queued word at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      inst_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      err_q      <= err_d;
      inst_cnt_q <= inst_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // FIFO storage; contents are masked by out_valid so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= enc_word;
    end
  end

  assign err_o      = err_q;
  assign inst_cnt_o = inst_cnt_q;
  assign err_cnt_o  = err_cnt_q;

endmodule
`default_nettype wire
